// File: rtl/axil_arbiter_priority_wr_pkg.sv
// Shared AXI-Lite interconnect definitions.
// Holds the arbiter FSM state encoding, shared by the write and read arbiters.
package axil_arbiter_priority_wr_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StResp   = 2'd2
  } axil_arb_state_e;

endpackage

// File: rtl/axil_arbiter_priority_wr_encoder.sv
// Fixed-priority encoder: index 0 has the highest priority.
// Produces a one-hot grant and its binary index. Both outputs are zero when req_i is zero.
module axil_priority_encoder #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IDX_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [IDX_WIDTH-1:0]   idx_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    // Walk from the highest index down, so the lowest set bit is written last and wins.
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/axil_arbiter_priority_wr.sv
// AXI-Lite write-path arbiter with fixed priority (master 0 highest).
// It holds the grant from AW/W acceptance through the B handshake. All outputs are registered.
module axil_arbiter_priority_wr
  import axil_arbiter_priority_wr_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IDX_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   aw_hs,
  input  logic                   w_hs,
  input  logic                   b_hs,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_WIDTH-1:0]   grant_idx,
  output logic                   busy
);

  axil_arb_state_e        state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   busy_q, busy_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;

  logic [NUM_MASTERS-1:0] enc_grant;
  logic [IDX_WIDTH-1:0]   enc_idx;

  axil_priority_encoder #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_encoder (
    .req_i  (req),
    .grant_o(enc_grant),
    .idx_o  (enc_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = enc_grant;
          idx_d   = enc_idx;
          busy_d  = 1'b1;
          state_d = StActive;
        end
      end
      StActive: begin
        // Both halves may complete in the same cycle or in either order.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StResp;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
        end
      end
      StResp: begin
        if (b_hs) begin
          grant_d = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d   = '0;
        idx_d     = '0;
        busy_d    = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_axil_arbiter_priority_wr.sv
// Directed bench for the write-path priority arbiter.
// Covers a four-master instance and a single-master instance.
module tb_axil_arbiter_priority_wr;

  logic       aclk;
  logic       areset;
  logic [3:0] req;
  logic       aw_hs, w_hs, b_hs;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;

  logic       req1;
  logic       aw1, w1, b1;
  logic       grant1;
  logic       idx1;
  logic       busy1;

  int checks;
  int errors;

  axil_arbiter_priority_wr #(
    .NUM_MASTERS(4),
    .IDX_WIDTH  (2)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .req      (req),
    .aw_hs    (aw_hs),
    .w_hs     (w_hs),
    .b_hs     (b_hs),
    .grant    (grant),
    .grant_idx(grant_idx),
    .busy     (busy)
  );

  axil_arbiter_priority_wr #(
    .NUM_MASTERS(1),
    .IDX_WIDTH  (1)
  ) dut1 (
    .aclk     (aclk),
    .areset   (areset),
    .req      (req1),
    .aw_hs    (aw1),
    .w_hs     (w1),
    .b_hs     (b1),
    .grant    (grant1),
    .grant_idx(idx1),
    .busy     (busy1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    req    = 4'b1111;
    tick();
    checks++;
    if (grant !== 4'b0000 || grant_idx !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grant=%b idx=%0d busy=%b, want 0000/0/0", grant, grant_idx, busy);
    end
    areset = 1'b0;
    req    = 4'b0000;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: grant=%b busy=%b, want 0000/0", grant, busy);
    end
  endtask

  task automatic test_grant();
    req = 4'b1010;
    tick();
    checks++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL grant_1010: grant=%b idx=%0d busy=%b, want 0010/1/1", grant, grant_idx, busy);
    end
  endtask

  task automatic test_hold();
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
      errors++;
      $display("FAIL hold_higher_req: grant=%b idx=%0d, want 0010/1", grant, grant_idx);
    end
    aw_hs = 1'b1;
    tick();
    aw_hs = 1'b0;
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_after_aw: grant=%b busy=%b, want 0010/1", grant, busy);
    end
    w_hs = 1'b1;
    tick();
    w_hs = 1'b0;
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_after_w: grant=%b busy=%b, want 0010/1", grant, busy);
    end
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    checks++;
    if (grant !== 4'b0000 || grant_idx !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_on_b: grant=%b idx=%0d busy=%b, want 0000/0/0", grant, grant_idx, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL regrant_after_idle: grant=%b idx=%0d busy=%b, want 0001/0/1", grant, grant_idx,
               busy);
    end
  endtask

  task automatic test_same_cycle();
    req   = 4'b0000;
    aw_hs = 1'b1;
    w_hs  = 1'b1;
    tick();
    aw_hs = 1'b0;
    w_hs  = 1'b0;
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL same_cycle_resp: grant=%b busy=%b, want 0001/1", grant, busy);
    end
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL same_cycle_b: grant=%b busy=%b, want 0000/0", grant, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL stay_idle: grant=%b busy=%b, want 0000/0", grant, busy);
    end
  endtask

  task automatic test_split();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    checks++;
    if (grant !== 4'b0100 || grant_idx !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL split_grant: grant=%b idx=%0d busy=%b, want 0100/2/1", grant, grant_idx, busy);
    end
    w_hs = 1'b1;
    tick();
    w_hs = 1'b0;
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL spurious_b_ignored: grant=%b busy=%b, want 0100/1", grant, busy);
    end
    tick();
    aw_hs = 1'b1;
    tick();
    aw_hs = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL split_resp_busy: busy=%b, want 1", busy);
    end
    // AW/W handshakes while waiting for B must not disturb the response phase.
    aw_hs = 1'b1;
    w_hs  = 1'b1;
    tick();
    aw_hs = 1'b0;
    w_hs  = 1'b0;
    b_hs  = 1'b1;
    tick();
    b_hs = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL split_release: grant=%b busy=%b, want 0000/0", grant, busy);
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b0001;
    tick();
    req   = 4'b0000;
    aw_hs = 1'b1;
    w_hs  = 1'b1;
    tick();
    aw_hs = 1'b0;
    w_hs  = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || grant_idx !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_resp: grant=%b idx=%0d busy=%b, want 0000/0/0", grant, grant_idx,
               busy);
    end
    areset = 1'b0;
    req    = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant: grant=%b idx=%0d busy=%b, want 1000/3/1", grant, grant_idx,
               busy);
    end
    req   = 4'b0000;
    aw_hs = 1'b1;
    tick();
    aw_hs = 1'b0;
    b_hs  = 1'b1;
    tick();
    b_hs = 1'b0;
    checks++;
    if (busy !== 1'b1 || grant !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset_aw_only: grant=%b busy=%b, want 1000/1", grant, busy);
    end
    w_hs = 1'b1;
    tick();
    w_hs = 1'b0;
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_release: grant=%b busy=%b, want 0000/0", grant, busy);
    end
  endtask

  task automatic test_single();
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    checks++;
    if (grant1 !== 1'b1 || idx1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b idx=%b busy=%b, want 1/0/1", grant1, idx1, busy1);
    end
    aw1 = 1'b1;
    tick();
    aw1 = 1'b0;
    w1  = 1'b1;
    tick();
    w1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || grant1 !== 1'b1) begin
      errors++;
      $display("FAIL single_resp: grant=%b busy=%b, want 1/1", grant1, busy1);
    end
    b1 = 1'b1;
    tick();
    b1 = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || grant1 !== 1'b0 || idx1 !== 1'b0) begin
      errors++;
      $display("FAIL single_release: grant=%b idx=%b busy=%b, want 0/0/0", grant1, idx1, busy1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    areset = 1'b1;
    req    = 4'b0000;
    aw_hs  = 1'b0;
    w_hs   = 1'b0;
    b_hs   = 1'b0;
    req1   = 1'b0;
    aw1    = 1'b0;
    w1     = 1'b0;
    b1     = 1'b0;
    test_reset();
    test_grant();
    test_hold();
    test_same_cycle();
    test_split();
    test_reset_mid();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
